// File: rtl/bgsub_frame_sequencer.sv
// Per-frame sequencer for the background-subtraction datapath: picks LEARN or COMPARE per frame,
// walks the frame-RAM read addresses and re-times the write/accumulate enables to the RAM read latency.
module bgsub_frame_sequencer #(
  parameter int ADDR_W     = 18,
  parameter int NUM_PIXELS = 76800,
  parameter int RD_LAT     = 2
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              vtcvde,
  input  logic              learn_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] ref_wr_addr,
  output logic              ref_wr_en,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              ref_valid,
  output logic              frame_done,
  output logic              overrun
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] PIX_END  = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NUM_PIXELS - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, LEARN, COMPARE, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic [2:0]       drain_cnt;
  logic             learn_pend;
  logic             learn_mode;

  logic [RD_LAT-1:0] vld_p;
  logic [ADDR_W-1:0] addr_p [RD_LAT];

  assign rd_addr = pix_cnt[ADDR_W-1:0];

  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    acc_clr    = 1'b0;
    frame_done = 1'b0;
    overrun    = frame_start && (state != IDLE);
    case (state)
      IDLE: begin
        if (frame_start) begin
          if (learn_pend || !ref_valid) begin
            state_nxt = LEARN;
          end else begin
            state_nxt = COMPARE;
            acc_clr   = 1'b1;
          end
        end
      end
      LEARN, COMPARE: begin
        if (pix_cnt >= PIX_END) begin
          state_nxt = DRAIN;
        end else if (vtcvde) begin
          rd_en = 1'b1;
          if (pix_cnt == PIX_LAST) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      drain_cnt  <= '0;
      learn_pend <= 1'b0;
      learn_mode <= 1'b0;
      ref_valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rd_en) pix_cnt <= pix_cnt + CNT_W'(1);
      else if (state == DONE) pix_cnt <= '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      // mode is latched for the whole frame so the tail of the pipeline drains in the right mode
      if (state == IDLE && frame_start) learn_mode <= (state_nxt == LEARN);
      // a request arriving on the LEARN entry cycle keeps the pending flag set
      if (learn_req) learn_pend <= 1'b1;
      else if (state == IDLE && state_nxt == LEARN) learn_pend <= 1'b0;
      if (state == DONE && learn_mode) ref_valid <= 1'b1;
    end
  end

  // p0..p(RD_LAT-1): read-enable/address delay matching the frame-RAM read latency
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_p[i] <= '0;
    end else begin
      vld_p[0]  <= rd_en;
      addr_p[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        addr_p[i] <= addr_p[i-1];
      end
    end
  end

  assign ref_wr_en   = vld_p[RD_LAT-1] & learn_mode;
  assign acc_en      = vld_p[RD_LAT-1] & ~learn_mode;
  assign ref_wr_addr = addr_p[RD_LAT-1];

endmodule

// File: tb/tb_bgsub_frame_sequencer.sv
// Directed bench for bgsub_frame_sequencer with a reduced frame size (1200 pixels) to keep runs short.
module tb_bgsub_frame_sequencer;

  localparam int ADDR_W = 11;
  localparam int NP     = 1200;
  localparam int RD_LAT = 2;

  logic              pclk = 1'b0;
  logic              reset = 1'b0;
  logic              frame_start = 1'b0;
  logic              vtcvde = 1'b0;
  logic              learn_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] ref_wr_addr;
  logic              ref_wr_en;
  logic              acc_clr;
  logic              acc_en;
  logic              ref_valid;
  logic              frame_done;
  logic              overrun;

  int checks = 0;
  int failures = 0;
  int cyc, n_rd, n_wr, n_acc, n_done, n_clr, n_ovr;
  int first_rd, first_wr, rd_err, wa_err, exp_ra, exp_wa;

  always #5 pclk = ~pclk;

  bgsub_frame_sequencer #(.ADDR_W(ADDR_W), .NUM_PIXELS(NP), .RD_LAT(RD_LAT)) dut (
    .pclk(pclk), .reset(reset), .frame_start(frame_start), .vtcvde(vtcvde), .learn_req(learn_req),
    .rd_addr(rd_addr), .rd_en(rd_en), .ref_wr_addr(ref_wr_addr), .ref_wr_en(ref_wr_en),
    .acc_clr(acc_clr), .acc_en(acc_en), .ref_valid(ref_valid), .frame_done(frame_done),
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    cyc = 0; n_rd = 0; n_wr = 0; n_acc = 0; n_done = 0; n_clr = 0; n_ovr = 0;
    first_rd = -1; first_wr = -1; rd_err = 0; wa_err = 0; exp_ra = 0; exp_wa = 0;
  endtask

  // sample on the falling edge, then move to just after the next rising edge to drive inputs
  task automatic tick();
    @(negedge pclk);
    cyc++;
    if (rd_en) begin
      if (first_rd < 0) first_rd = cyc;
      if (int'(rd_addr) != exp_ra) rd_err++;
      exp_ra++;
      n_rd++;
    end
    if (rd_en && !vtcvde) rd_err++;
    if (ref_wr_en) begin
      if (first_wr < 0) first_wr = cyc;
      if (int'(ref_wr_addr) != exp_wa) wa_err++;
      exp_wa++;
      n_wr++;
    end
    if (acc_en) n_acc++;
    if (frame_done) n_done++;
    if (acc_clr) n_clr++;
    if (overrun) n_ovr++;
    @(posedge pclk);
    #1;
  endtask

  task automatic run_frame(input bit toggle, input int lreq_at, input int fs_at);
    int hi = 0;
    int guard = 0;
    bit ph = 1'b0;
    clr_stats();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    learn_req = 1'b0;
    while (hi < NP && guard < 4 * NP) begin
      vtcvde      = toggle ? !ph : 1'b1;
      learn_req   = vtcvde && (hi == lreq_at);
      frame_start = vtcvde && (hi == fs_at);
      tick();
      if (vtcvde) hi++;
      ph = !ph;
      guard++;
    end
    learn_req = 1'b0;
    frame_start = 1'b0;
    vtcvde = 1'b1;
    for (int i = 0; i < 16 && n_done == 0; i++) tick();
    vtcvde = 1'b0;
    tick();
    tick();
    chk("frame_done_count", 32'(n_done), 32'(1));
    chk("rd_count", 32'(n_rd), 32'(NP));
    chk("rd_addr_seq_errors", 32'(rd_err), 32'(0));
    chk("wr_addr_seq_errors", 32'(wa_err), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr_stats();
    // reset held with active-looking inputs
    reset = 1'b0;
    frame_start = 1'b1;
    vtcvde = 1'b1;
    tick();
    tick();
    chk("rst_rd_en", 32'(rd_en), 32'(0));
    chk("rst_rd_addr", 32'(rd_addr), 32'(0));
    chk("rst_ref_wr_en", 32'(ref_wr_en), 32'(0));
    chk("rst_ref_wr_addr", 32'(ref_wr_addr), 32'(0));
    chk("rst_acc_en", 32'(acc_en), 32'(0));
    chk("rst_ref_valid", 32'(ref_valid), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    frame_start = 1'b0;
    vtcvde = 1'b0;
    reset = 1'b1;
    tick();

    // first frame after reset is learned
    run_frame(1'b0, -1, -1);
    chk("t1_ref_wr_count", 32'(n_wr), 32'(NP));
    chk("t1_acc_en_count", 32'(n_acc), 32'(0));
    chk("t1_acc_clr_count", 32'(n_clr), 32'(0));
    chk("t1_wr_latency", 32'(first_wr - first_rd), 32'(RD_LAT));
    chk("t1_ref_valid", 32'(ref_valid), 32'(1));

    // plain compare frame
    run_frame(1'b0, -1, -1);
    chk("t2_acc_en_count", 32'(n_acc), 32'(NP));
    chk("t2_ref_wr_count", 32'(n_wr), 32'(0));
    chk("t2_acc_clr_count", 32'(n_clr), 32'(1));

    // vtcvde toggling
    run_frame(1'b1, -1, -1);
    chk("t3_acc_en_count", 32'(n_acc), 32'(NP));
    chk("t3_ref_wr_count", 32'(n_wr), 32'(0));

    // learn request mid-compare
    run_frame(1'b0, 300, -1);
    chk("t4a_acc_en_count", 32'(n_acc), 32'(NP));
    chk("t4a_ref_wr_count", 32'(n_wr), 32'(0));
    run_frame(1'b0, -1, -1);
    chk("t4b_ref_wr_count", 32'(n_wr), 32'(NP));
    chk("t4b_acc_en_count", 32'(n_acc), 32'(0));
    chk("t4b_acc_clr_count", 32'(n_clr), 32'(0));
    run_frame(1'b0, -1, -1);
    chk("t4c_acc_en_count", 32'(n_acc), 32'(NP));
    chk("t4c_acc_clr_count", 32'(n_clr), 32'(1));

    // frame_start at pixel 1000
    run_frame(1'b0, -1, 1000);
    chk("t5_overrun_count", 32'(n_ovr), 32'(1));
    chk("t5_acc_en_count", 32'(n_acc), 32'(NP));

    // learn_req coinciding with LEARN entry keeps the request pending
    learn_req = 1'b1;
    tick();
    run_frame(1'b0, -1, -1);
    chk("t7a_ref_wr_count", 32'(n_wr), 32'(NP));
    run_frame(1'b0, -1, -1);
    chk("t7b_ref_wr_count", 32'(n_wr), 32'(NP));
    chk("t7b_acc_en_count", 32'(n_acc), 32'(0));

    // reset mid compare frame at pixel 500
    clr_stats();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    vtcvde = 1'b1;
    for (int i = 0; i < 500; i++) tick();
    chk("t6_pre_acc_en", 32'(acc_en), 32'(1));
    chk("t6_pre_ref_valid", 32'(ref_valid), 32'(1));
    reset = 1'b0;
    #1;
    chk("t6_abort_rd_en", 32'(rd_en), 32'(0));
    chk("t6_abort_rd_addr", 32'(rd_addr), 32'(0));
    chk("t6_abort_acc_en", 32'(acc_en), 32'(0));
    chk("t6_abort_ref_wr_addr", 32'(ref_wr_addr), 32'(0));
    chk("t6_abort_ref_valid", 32'(ref_valid), 32'(0));
    vtcvde = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_frame(1'b0, -1, -1);
    chk("t6_next_ref_wr_count", 32'(n_wr), 32'(NP));
    chk("t6_next_acc_en_count", 32'(n_acc), 32'(0));
    chk("t6_next_ref_valid", 32'(ref_valid), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
